fft_power_peak: RTL

//  Downstream of the FFT core: consumes its AXI-Stream output frame (one complex bin per beat) and emits the power spectrum.
//  Per bin: |X|^2 = re^2 + im^2. Tracks the strongest bin of each frame and reports its index and power at frame end.

---
 rtl/fft_pkg.sv | 20 ++
 rtl/cplx_sq_mag.sv | 38 +++
 rtl/fft_power_peak.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT power/peak post-processing block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: tdata width, frame size, bin index width, re/im slice positions, power_t.
package fft_pkg;

  localparam int WIDTH  = 64;
  localparam int N_BINS = 1024;
  localparam int BIN_W  = 10;
  localparam int COMP_W = 32;

  // Complex beat packing: real part in the upper half, imaginary in the lower half.
  localparam int RE_MSB = 63;
  localparam int RE_LSB = 32;
  localparam int IM_MSB = 31;
  localparam int IM_LSB = 0;

  typedef logic [WIDTH-1:0] power_t;

endpackage

// File: rtl/cplx_sq_mag.sv
// Squared magnitude re^2 + im^2 of a signed complex sample, two register stages.
// Latency: 2 enabled cycles (stage 1 = squares, stage 2 = sum).
// Backpressure: stages only move when en is high; all state holds otherwise.
// Ports: clk, rst (async, active low), en, re/im (signed COMP_W), pwr (unsigned power_t).
module cplx_sq_mag
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [COMP_W-1:0] re,
  input  logic signed [COMP_W-1:0] im,
  output power_t                   pwr
);

  // Operands are sign-extended to 64 bits before multiplying, so (-2^31)^2 = 2^62 is exact.
  logic signed [2*COMP_W-1:0] re_sq;
  logic signed [2*COMP_W-1:0] im_sq;
  power_t                     re2;
  power_t                     im2;

  assign re_sq = re * re;
  assign im_sq = im * im;

  // Each square is at most 2^62, so the sum is at most 2^63 and never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      re2 <= '0;
      im2 <= '0;
      pwr <= '0;
    end else if (en) begin
      re2 <= power_t'(re_sq);
      im2 <= power_t'(im_sq);
      pwr <= re2 + im2;
    end
  end

endmodule

// File: rtl/fft_power_peak.sv
// Power spectrum |X|^2 of an FFT output stream plus per-frame peak bin/power report.
// Latency: 2 cycles from s00 accept to m00 valid; peak_valid 1 cycle after the closing m00 transfer.
// Backpressure: whole pipeline stalls together when output is valid and m00_axis_tready is low.
// Ports: s00_axis_* complex bins in, m00_axis_* power out, peak_bin/peak_pwr/peak_valid/frame_err sideband.
// Build option: define PWR_PEAK_SKIP_DC_EN to exclude bin 0 (DC) from the peak search.
module fft_power_peak
  import fft_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   s00_axis_tdata,
  input  logic               s00_axis_tvalid,
  input  logic               s00_axis_tlast,
  output logic               s00_axis_tready,
  output logic [WIDTH-1:0]   m00_axis_tdata,
  output logic               m00_axis_tvalid,
  output logic               m00_axis_tlast,
  output logic [WIDTH/8-1:0] m00_axis_tstrb,
  input  logic               m00_axis_tready,
  output logic [BIN_W-1:0]   peak_bin,
  output power_t             peak_pwr,
  output logic               peak_valid,
  output logic               frame_err
);

  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N_BINS - 1);

  logic             advance;
  logic             s1_valid, s1_last;
  logic             s2_valid, s2_last;
  power_t           s2_pwr;
  logic             xfer, cnt_full, close, take;
  logic [BIN_W-1:0] cnt;
  logic [BIN_W-1:0] run_bin, cand_bin;
  power_t           run_max, cand_pwr;

  // A bubble in stage 1 is not squeezed out during a stall; every stage moves in lock-step.
  assign advance         = !s2_valid || m00_axis_tready;
  assign s00_axis_tready = advance;

  cplx_sq_mag u_sq (
    .clk (clk),
    .rst (rst),
    .en  (advance),
    .re  (s00_axis_tdata[RE_MSB:RE_LSB]),
    .im  (s00_axis_tdata[IM_MSB:IM_LSB]),
    .pwr (s2_pwr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
    end else if (advance) begin
      s1_valid <= s00_axis_tvalid;
      s1_last  <= s00_axis_tlast && s00_axis_tvalid;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
    end
  end

  assign m00_axis_tdata  = s2_pwr;
  assign m00_axis_tvalid = s2_valid;
  assign m00_axis_tlast  = s2_last;
  assign m00_axis_tstrb  = '1;

  // Frames close on tlast, or on the last legal bin when tlast never came.
  assign xfer     = s2_valid && m00_axis_tready;
  assign cnt_full = (cnt == LAST_BIN);
  assign close    = s2_last || cnt_full;

  // cnt is the index of the beat now at the output. Strictly-greater keeps the lowest index on ties;
  // the first candidate bin of a frame loads regardless of the (reset) running max.
`ifdef PWR_PEAK_SKIP_DC_EN
  assign take = (cnt != '0) && ((cnt == BIN_W'(1)) || (s2_pwr > run_max));
`else
  assign take = (cnt == '0) || (s2_pwr > run_max);
`endif

  // Running max with the current beat folded in, used both to update and to report at frame close.
  always_comb begin
    cand_pwr = run_max;
    cand_bin = run_bin;
    if (take) begin
      cand_pwr = s2_pwr;
      cand_bin = cnt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      run_max    <= '0;
      run_bin    <= '0;
      peak_bin   <= '0;
      peak_pwr   <= '0;
      peak_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      peak_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (xfer) begin
        if (close) begin
          cnt        <= '0;
          peak_bin   <= cand_bin;
          peak_pwr   <= cand_pwr;
          peak_valid <= 1'b1;
          // Only a tlast on exactly the last bin is a well-formed frame.
          frame_err  <= !(s2_last && cnt_full);
          run_max    <= '0;
          run_bin    <= '0;
        end else begin
          cnt     <= cnt + BIN_W'(1);
          run_max <= cand_pwr;
          run_bin <= cand_bin;
        end
      end
    end
  end

endmodule
